div_clk_meter: RTL and testbench



---
 rtl/div_clk_meter_pkg.sv | 13 +
 rtl/div_clk_meter_sync.sv | 20 ++
 rtl/div_clk_meter.sv | 109 ++++++++++
 tb/tb_div_clk_meter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_meter_pkg.sv
// Shared types and defaults for the divided-clock period/duty meter.
package div_clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meas_state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/div_clk_meter_sync.sv
// N-stage flop synchronizer for a single asynchronous bit, async reset to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/div_clk_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles,
// one result per input cycle, with a timeout for missing rising edges.
module div_clk_meter
    import div_clk_meter_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT     = 32'h0000_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             sig_s, sig_d, rise;
    meas_state_t      state, state_nxt;
    logic             start, report, expire;
    logic [CNT_W-1:0] cnt_p, cnt_h;

    // Synchronizer and edge register keep running in IDLE so enabling never sees a stale edge.
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .q   (sig_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_d <= 1'b0;
        else     sig_d <= sig_s;
    end

    assign rise = sig_s & ~sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Disable overrides everything; in MEAS a rise beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        report    = 1'b0;
        expire    = 1'b0;
        if (!meas_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: if (rise) begin
                    state_nxt = MEAS;
                    start     = 1'b1;
                end
                MEAS: if (rise) begin
                    report = 1'b1;
                end else if (cnt_p == TO_CNT) begin
                    expire    = 1'b1;
                    state_nxt = ARM;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p      <= '0;
            cnt_h      <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= report;
            timeout    <= expire;
            if (report) begin
                period    <= cnt_p;
                high_time <= cnt_h;
            end
            // The rise cycle itself is high and opens the next period.
            if (start || report) begin
                cnt_p <= ONE;
                cnt_h <= ONE;
            end else if (state_nxt == MEAS) begin
                cnt_p <= cnt_p + ONE;
                cnt_h <= cnt_h + {{(CNT_W-1){1'b0}}, sig_s};
            end else begin
                cnt_p <= '0;
                cnt_h <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_meter.sv
// Directed bench for div_clk_meter: clk-aligned sig_in waveforms, outputs sampled on negedge.
module tb_div_clk_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        meas_en = 1'b0;
    logic [15:0] period, high_time, period16, high_time16;
    logic        meas_valid, timeout, busy;
    logic        meas_valid16, timeout16, busy16;

    div_clk_meter dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    div_clk_meter #(.TIMEOUT(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .period     (period16),
        .high_time  (high_time16),
        .meas_valid (meas_valid16),
        .timeout    (timeout16),
        .busy       (busy16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int j;
        int p;
        int h;
    } ev_t;

    int   n_chk = 0;
    int   n_err = 0;
    ev_t  vq[$];
    int   tq[$];
    int   sp[100];
    int   sb[100];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ev_j(input int i);
        return (i < vq.size()) ? vq[i].j : -1;
    endfunction

    function automatic int ev_p(input int i);
        return (i < vq.size()) ? vq[i].p : -1;
    endfunction

    function automatic int ev_h(input int i);
        return (i < vq.size()) ? vq[i].h : -1;
    endfunction

    function automatic logic pat(input int id, input int j);
        case (id)
            1, 5:    return (j % 5) < 3;
            2:       return (j % 20) < 7;
            3:       return (j >= 4) && (((j - 4) % 8) < 4);
            4:       return (j < 3) || (j >= 5 && j < 8) || (j >= 35 && ((j - 35) % 10) < 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic prelude(input logic lev);
        sig_in  = lev;
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        meas_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input logic lev);
        rst     = 1'b1;
        sig_in  = lev;
        meas_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prelude(lev);
    endtask

    // Iteration j samples outputs, then drives the pattern value for step j.
    task automatic run(input int id, input int n, input bit use16);
        logic v, t, pv;
        int   p, h, b;
        vq.delete();
        tq.delete();
        pv = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            v = use16 ? meas_valid16 : meas_valid;
            t = use16 ? timeout16 : timeout;
            p = use16 ? int'(period16) : int'(period);
            h = use16 ? int'(high_time16) : int'(high_time);
            b = use16 ? int'(busy16) : int'(busy);
            sp[j] = p;
            sb[j] = b;
            if (v) begin
                chk($sformatf("t%0d_b2b_valid", id), int'(pv), 0);
                vq.push_back(ev_t'{j, p, h});
            end
            if (t) tq.push_back(j);
            pv      = v;
            sig_in  = pat(id, j);
            meas_en = !(id == 5 && j >= 14 && j < 20);
        end
    endtask

    task automatic chk_ev(input string tag, input int n, input int first, input int step,
                          input int ep, input int eh);
        chk({tag, "_nvalid"}, vq.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_j%0d", tag, i), ev_j(i), first + i * step);
            chk($sformatf("%s_p%0d", tag, i), ev_p(i), ep);
            chk($sformatf("%s_h%0d", tag, i), ev_h(i), eh);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"},    int'(period), 0);
        chk({tag, "_high_time"}, int'(high_time), 0);
        chk({tag, "_valid"},     int'(meas_valid), 0);
        chk({tag, "_timeout"},   int'(timeout), 0);
        chk({tag, "_busy"},      int'(busy), 0);
    endtask

    initial begin
        @(negedge clk);
        chk_zero("reset");
        chk("reset_busy16", int'(busy16), 0);

        // Divide-by-5, high 3 / low 2
        do_reset(1'b0);
        run(1, 30, 1'b0);
        chk_ev("t1", 5, 8, 5, 5, 3);
        chk("t1_ntimeout", tq.size(), 0);

        // Slow clock, high 7 / low 13
        do_reset(1'b0);
        run(2, 80, 1'b0);
        chk_ev("t2", 3, 23, 20, 20, 7);
        chk("t2_ntimeout", tq.size(), 0);

        // Input already high at enable, then 4/4
        do_reset(1'b1);
        run(3, 36, 1'b0);
        chk_ev("t3", 3, 15, 8, 8, 4);

        // Timeout with TIMEOUT=16, then re-arm and a period of 10
        do_reset(1'b0);
        run(4, 50, 1'b1);
        chk("t4_nvalid", vq.size(), 2);
        chk("t4_j0", ev_j(0), 8);
        chk("t4_p0", ev_p(0), 5);
        chk("t4_h0", ev_h(0), 3);
        chk("t4_ntimeout", tq.size(), 1);
        chk("t4_timeout_j", (tq.size() > 0) ? tq[0] : -1, 24);
        chk("t4_held_period", sp[30], 5);
        chk("t4_armed_busy", sb[30], 1);
        chk("t4_j1", ev_j(1), 48);
        chk("t4_p1", ev_p(1), 10);
        chk("t4_h1", ev_h(1), 5);

        // meas_en dropped mid-period, then re-enabled
        do_reset(1'b0);
        run(5, 36, 1'b0);
        chk("t5_nvalid", vq.size(), 4);
        chk("t5_j0", ev_j(0), 8);
        chk("t5_j1", ev_j(1), 13);
        chk("t5_j2", ev_j(2), 28);
        chk("t5_j3", ev_j(3), 33);
        chk("t5_p2", ev_p(2), 5);
        chk("t5_h2", ev_h(2), 3);
        chk("t5_busy_before", sb[14], 1);
        chk("t5_busy_drop", sb[15], 0);
        chk("t5_busy_idle", sb[19], 0);
        chk("t5_held_period", sp[19], 5);
        chk("t5_busy_rearm", sb[21], 1);
        chk("t5_ntimeout", tq.size(), 0);

        // Async reset between clock edges mid-MEAS
        do_reset(1'b0);
        run(1, 12, 1'b0);
        chk("t6_pre_nvalid", vq.size(), 1);
        chk("t6_pre_period", int'(period), 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("t6_async");
        @(negedge clk);
        rst = 1'b0;
        prelude(1'b0);
        run(1, 30, 1'b0);
        chk_ev("t6", 5, 8, 5, 5, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
